desmultiplexador8_serial: RTL and testbench
===========================================

Name: desmultiplexador8_serial

Overview:
- Receive-side counterpart of the 8-to-1 selector path: rebuilds an 8-bit word from a serial stream of one bit per slot.
- Drives the 3-bit slot index (Sel) so the sending 8:1 multiplexer and this block step through slots 0..7 in lockstep.
- Publishes each completed word on a registered parallel bus with a one-cycle strobe.
- Sits between the serial link and the parallel consumer logic.

Parameters:
- LSB_PRIMEIRO, 1: slot k is written to B[k] when 1, to B[7-k] when 0.
- MAX_ESPERA, 15: maximum consecutive cycles in RECEBE without ent_valido before the frame is aborted; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- ent  input  1  serial data bit for the current slot.
- ent_valido  input  1  ent holds a valid bit this cycle.
- inicio  input  1  frame-start request, one-cycle pulse.
- Sel  output  3  current slot index, registered, fed to the remote multiplexer select.
- B  output  8  last complete word, registered.
- pronto  output  1  one-cycle strobe: B was updated this cycle.
- ocupado  output  1  high while a frame is being received.
- erro  output  1  one-cycle strobe: frame aborted by restart or timeout.

Behaviour:
- Reset, asynchronous and active-high, with immediate effect:
  - Forces state IDLE.
  - Sel=0, B=0x00, pronto=0, ocupado=0, erro=0.
  - Clears the partial-word register and the timeout counter.
  - Reset asserted mid-frame discards the partial word; B is not updated.
- States: IDLE, RECEBE, PRONTO.
- IDLE:
  - Sel=0, ocupado=0; ent and ent_valido are ignored.
  - inicio=1 -> RECEBE: Sel=0, timeout counter=0, partial word cleared.
- RECEBE:
  - ocupado=1.
  - ent_valido=1: write ent into the partial bit chosen by Sel (mapped by LSB_PRIMEIRO), then Sel<=Sel+1 and timeout counter<=0.
  - ent_valido=1 with Sel=7:
    - Load B with the full word, including this final bit, on the same edge.
    - Go to PRONTO; Sel wraps to 0.
  - ent_valido=0: timeout counter increments.
  - Timeout: when the counter reaches MAX_ESPERA, go to IDLE, pulse erro for one cycle, Sel=0, B unchanged.
  - inicio=1 in RECEBE, with priority over ent_valido in the same cycle:
    - Pulse erro for one cycle and clear the partial word.
    - Sel=0, timeout counter=0; stay in RECEBE, so the new frame starts.
- PRONTO (exactly one cycle):
  - pronto=1, ocupado=0, Sel=0.
  - inicio=1 in this cycle -> RECEBE directly (back-to-back frames, no lost cycle); otherwise -> IDLE.
- Latency: pronto and the new B value are visible the cycle after the edge that captured slot 7.
- Minimum frame length is 9 cycles from inicio to pronto (8 data cycles plus PRONTO). pronto never asserts in the same cycle as erro.
- B changes only on complete frames; aborted or partial frames never disturb it.
- Sel is registered and glitch-free; it changes only on clk edges.

Test Plan:
- Reset: assert rst mid-frame after 4 bits -> all outputs 0 asynchronously; after release, B stays 0x00 and state is IDLE.
- Basic frame, LSB_PRIMEIRO=1: inicio, then ent=1,0,1,0,0,1,0,1 with ent_valido held 1 -> Sel steps 0..7, B=0xA5, pronto high one cycle, ocupado low afterwards.
- Bit order, LSB_PRIMEIRO=0: same stimulus -> B=0xA5 bit-reversed = 0xA5 (palindrome); repeat with 1,1,1,1,0,0,0,0 -> B=0xF0 (vs 0x0F when LSB_PRIMEIRO=1).
- Gaps and timeout:
  - Frame with idle gaps of 3 cycles between bits -> completes correctly, Sel holds during gaps.
  - Gap of 15 cycles after bit 2 -> erro pulse, state IDLE, B keeps its prior value.
- Restart mid-frame: inicio asserted with ent_valido=1 at Sel=5 -> erro pulse, Sel=0, that bit is discarded; the next 8 valid bits form B.
- Back-to-back frames: inicio asserted in the PRONTO cycle -> the next frame starts without an IDLE cycle; two consecutive pronto pulses exactly 9 cycles apart, with B=0x3C then 0xC3.

Source files
------------

// File: rtl/desmultiplexador8_serial.sv
// desmultiplexador8_serial
// Serial-to-parallel receiver paired with a remote 8:1 multiplexer.
// Sel walks slots 0..7 in lockstep with the sender. Each valid bit is
// written into a partial word, and a completed word is published on B
// together with a one-cycle pronto strobe. erro pulses for one cycle
// when a frame is aborted by a restart or by a timeout.
module desmultiplexador8_serial #(
    parameter int LSB_PRIMEIRO = 1,
    parameter int MAX_ESPERA   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ent,
    input  logic       ent_valido,
    input  logic       inicio,
    output logic [2:0] Sel,
    output logic [7:0] B,
    output logic       pronto,
    output logic       ocupado,
    output logic       erro
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RECEBE = 2'd1;
    localparam logic [1:0] PRONTO = 2'd2;

    // The timeout fires on the edge where the idle count would reach MAX_ESPERA.
    localparam logic [7:0] LIMITE = 8'(MAX_ESPERA - 1);

    logic [1:0] estado;
    logic [7:0] parcial;
    logic [7:0] parcial_novo;
    logic [7:0] contador;
    logic [2:0] indice;

    // Maps the current slot to its bit position in the word.
    always_comb begin
        indice = (LSB_PRIMEIRO != 0) ? Sel : (3'd7 - Sel);
        parcial_novo = parcial;
        parcial_novo[indice] = ent;
    end

    // Both strobe-like status flags come straight from the state register.
    assign pronto  = (estado == PRONTO);
    assign ocupado = (estado == RECEBE);

    // Frame state machine, slot counter, partial word, timeout and output word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado   <= IDLE;
            Sel      <= 3'd0;
            parcial  <= 8'h00;
            contador <= 8'h00;
            B        <= 8'h00;
            erro     <= 1'b0;
        end else begin
            erro <= 1'b0;
            case (estado)
                IDLE: begin
                    Sel <= 3'd0;
                    if (inicio) begin
                        estado   <= RECEBE;
                        contador <= 8'h00;
                        parcial  <= 8'h00;
                    end
                end
                RECEBE: begin
                    if (inicio) begin
                        // Restart wins over a valid bit in the same cycle.
                        erro     <= 1'b1;
                        parcial  <= 8'h00;
                        Sel      <= 3'd0;
                        contador <= 8'h00;
                    end else if (ent_valido) begin
                        parcial  <= parcial_novo;
                        contador <= 8'h00;
                        if (Sel == 3'd7) begin
                            // Last slot: publish the word including this bit.
                            B      <= parcial_novo;
                            estado <= PRONTO;
                            Sel    <= 3'd0;
                        end else begin
                            Sel <= Sel + 3'd1;
                        end
                    end else if (contador == LIMITE) begin
                        estado   <= IDLE;
                        erro     <= 1'b1;
                        Sel      <= 3'd0;
                        contador <= 8'h00;
                    end else begin
                        contador <= contador + 8'h01;
                    end
                end
                PRONTO: begin
                    Sel <= 3'd0;
                    if (inicio) begin
                        estado   <= RECEBE;
                        contador <= 8'h00;
                        parcial  <= 8'h00;
                    end else begin
                        estado <= IDLE;
                    end
                end
                default: begin
                    estado <= IDLE;
                    Sel    <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_desmultiplexador8_serial.sv
// Bench for desmultiplexador8_serial: two instances (LSB-first and
// MSB-first) share the stimulus; expected words go into per-instance
// queues and are compared when pronto is seen.
module tb_desmultiplexador8_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       ent;
    logic       ent_valido;
    logic       inicio;
    logic [2:0] sel1, sel0;
    logic [7:0] b1, b0;
    logic       pronto1, pronto0, ocupado1, ocupado0, erro1, erro0;

    int checks   = 0;
    int failures = 0;
    logic [7:0] q1[$];
    logic [7:0] q0[$];

    always #5 clk = ~clk;

    desmultiplexador8_serial #(.LSB_PRIMEIRO(1), .MAX_ESPERA(15)) dut1 (
        .clk(clk), .rst(rst), .ent(ent), .ent_valido(ent_valido), .inicio(inicio),
        .Sel(sel1), .B(b1), .pronto(pronto1), .ocupado(ocupado1), .erro(erro1)
    );

    desmultiplexador8_serial #(.LSB_PRIMEIRO(0), .MAX_ESPERA(15)) dut0 (
        .clk(clk), .rst(rst), .ent(ent), .ent_valido(ent_valido), .inicio(inicio),
        .Sel(sel0), .B(b0), .pronto(pronto0), .ocupado(ocupado0), .erro(erro0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rev(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_word(input logic [7:0] s);
        q1.push_back(s);
        q0.push_back(rev(s));
    endtask

    task automatic start;
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
    endtask

    // s[k] is the bit sent in slot k; gap idle cycles follow each bit but the last.
    task automatic send_bits(input logic [7:0] s, input int gap);
        for (int k = 0; k < 8; k++) begin
            chk("sel_slot", 32'(sel1), 32'(k));
            ent = s[k];
            ent_valido = 1'b1;
            tick();
            ent_valido = 1'b0;
            ent = 1'b0;
            if (k < 7) begin
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("sel_hold", 32'(sel1), 32'(k + 1));
                end
            end
        end
    endtask

    // Scoreboard side: every pronto pops one expected word per instance.
    always @(negedge clk) begin
        if (pronto1 === 1'b1) begin
            if (q1.size() == 0) chk("pronto1_unexpected", 32'(pronto1), 32'h0);
            else chk("B_lsb", 32'(b1), 32'(q1.pop_front()));
            chk("pronto_erro_excl", 32'(erro1), 32'h0);
        end
        if (pronto0 === 1'b1) begin
            if (q0.size() == 0) chk("pronto0_unexpected", 32'(pronto0), 32'h0);
            else chk("B_msb", 32'(b0), 32'(q0.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ent = 1'b0; ent_valido = 1'b0; inicio = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_sel", 32'(sel1), 32'h0);
        chk("rst_b", 32'(b1), 32'h0);
        chk("rst_pronto", 32'(pronto1), 32'h0);
        chk("rst_ocupado", 32'(ocupado1), 32'h0);
        chk("rst_erro", 32'(erro1), 32'h0);
        rst = 1'b0;
        tick();

        // Reset in the middle of a frame after four bits
        start();
        for (int k = 0; k < 4; k++) begin
            ent = 1'b1; ent_valido = 1'b1; tick();
        end
        ent_valido = 1'b0;
        chk("mid_sel_before_rst", 32'(sel1), 32'h4);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sel", 32'(sel1), 32'h0);
        chk("async_rst_ocupado", 32'(ocupado1), 32'h0);
        chk("async_rst_b", 32'(b1), 32'h0);
        chk("async_rst_pronto", 32'(pronto1), 32'h0);
        #1 rst = 1'b0;
        tick();
        chk("post_rst_b", 32'(b1), 32'h0);
        chk("post_rst_idle", 32'(ocupado1), 32'h0);
        tick();

        // Basic frame 1,0,1,0,0,1,0,1
        expect_word(8'hA5);
        start();
        chk("frame_ocupado", 32'(ocupado1), 32'h1);
        send_bits(8'hA5, 0);
        chk("basic_pronto", 32'(pronto1), 32'h1);
        chk("basic_ocupado_low", 32'(ocupado1), 32'h0);
        chk("basic_sel_wrap", 32'(sel1), 32'h0);
        tick();
        chk("basic_pronto_1cyc", 32'(pronto1), 32'h0);
        chk("basic_b_hold", 32'(b1), 32'hA5);

        // Bit order 1,1,1,1,0,0,0,0
        expect_word(8'h0F);
        start();
        send_bits(8'h0F, 0);
        tick();
        chk("order_lsb", 32'(b1), 32'h0F);
        chk("order_msb", 32'(b0), 32'hF0);

        // Frame with 3-cycle gaps between bits
        expect_word(8'h96);
        start();
        send_bits(8'h96, 3);
        chk("gap_pronto", 32'(pronto1), 32'h1);
        tick();

        // Timeout after bit 2
        start();
        for (int k = 0; k < 3; k++) begin
            ent = 1'b1; ent_valido = 1'b1; tick();
        end
        ent_valido = 1'b0; ent = 1'b0;
        repeat (14) tick();
        chk("timeout_not_yet", 32'(erro1), 32'h0);
        chk("timeout_still_busy", 32'(ocupado1), 32'h1);
        tick();
        chk("timeout_erro", 32'(erro1), 32'h1);
        chk("timeout_idle", 32'(ocupado1), 32'h0);
        chk("timeout_sel", 32'(sel1), 32'h0);
        chk("timeout_b_kept", 32'(b1), 32'h96);
        chk("timeout_b0_kept", 32'(b0), 32'h69);
        chk("timeout_no_pronto", 32'(pronto1), 32'h0);
        tick();
        chk("timeout_erro_1cyc", 32'(erro1), 32'h0);

        // Restart with a valid bit at Sel=5
        start();
        for (int k = 0; k < 5; k++) begin
            ent = 1'b1; ent_valido = 1'b1; tick();
        end
        chk("restart_sel5", 32'(sel1), 32'h5);
        inicio = 1'b1; ent = 1'b1; ent_valido = 1'b1;
        tick();
        inicio = 1'b0; ent_valido = 1'b0; ent = 1'b0;
        chk("restart_erro", 32'(erro1), 32'h1);
        chk("restart_sel0", 32'(sel1), 32'h0);
        chk("restart_busy", 32'(ocupado1), 32'h1);
        expect_word(8'h21);
        send_bits(8'h21, 0);
        chk("restart_pronto", 32'(pronto1), 32'h1);
        chk("restart_no_erro", 32'(erro1), 32'h0);
        tick();

        // Back-to-back frames, inicio in the PRONTO cycle
        expect_word(8'h3C);
        expect_word(8'hC3);
        start();
        send_bits(8'h3C, 0);
        chk("b2b_first_pronto", 32'(pronto1), 32'h1);
        inicio = 1'b1;
        tick();
        inicio = 1'b0;
        chk("b2b_no_idle", 32'(ocupado1), 32'h1);
        chk("b2b_pronto_low", 32'(pronto1), 32'h0);
        send_bits(8'hC3, 0);
        chk("b2b_second_pronto_9", 32'(pronto1), 32'h1);
        tick();
        chk("b2b_b_final", 32'(b1), 32'hC3);
        chk("b2b_idle_after", 32'(ocupado1), 32'h0);
        tick();

        chk("queue1_drained", 32'(q1.size()), 32'h0);
        chk("queue0_drained", 32'(q0.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
